debug_slave_cmd_queue: RTL
==========================

# debug_slave_cmd_queue

Parametrised successor to the debug-slave sysclk stage. It brings JTAG virtual-state update strobes (UDR/UIR) into the system clock domain and captures the scanned data register with its instruction. It queues each capture in a DEPTH-entry FIFO so that back-to-back JTAG commands are not lost while the CPU-side debug logic is busy, and presents the queue to that logic through a valid/ready handshake.

## Interface
Parameters:
- DATA_W, 38: width of scanned data register `sr` and of `cmd_data`.
- IR_W, 2: width of virtual IR; NUM_IR = 2**IR_W.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2: synchroniser flops per strobe; ≥2.
- ACTION_BIT, 37: bit of `cmd_data` that selects action vs no-action.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- vs_udr  in  1  async level from TCK domain, update-DR.
- vs_uir  in  1  async level from TCK domain, update-IR.
- ir_in  in  IR_W  virtual IR; quasi-static around strobes.
- sr  in  DATA_W  scanned data; stable from UDR rise until next shift.
- cmd_ready  in  1  consumer accepts head entry.
- clear_overflow  in  1  clears `overflow`.
- cmd_valid  out  1  FIFO non-empty.
- cmd_data  out  DATA_W  head data (`jdo` equivalent).
- cmd_ir  out  IR_W  head IR.
- take_action  out  NUM_IR  one-hot of `cmd_ir`, gated by cmd_valid & cmd_data[ACTION_BIT].
- take_no_action  out  NUM_IR  same, gated by ~cmd_data[ACTION_BIT].
- ir_update  out  1  one-cycle pulse on synchronised UIR edge.
- ir_value  out  IR_W  `ir_in` registered at the ir_update edge.
- fifo_level  out  $clog2(DEPTH)+1  entry count.
- overflow  out  1  sticky, a command was dropped.

## Operation
- Each strobe passes through the synchroniser chain s[0..SYNC_STAGES-1]. The rise detector is `edge = s[last] & ~prev & armed`.
- `armed` clears on reset and sets in the first cycle in which s[last]==0. A strobe held high across reset release therefore generates no event.
- UDR event: push {ir_in, sr} on the following clk edge.
  - If the FIFO is full and there is no pop in the same cycle, drop the entry and set `overflow`.
  - If the FIFO is full and a pop occurs in the same cycle, accept the push.
- UIR event: on the following clk edge, `ir_update`=1 for one cycle and `ir_value`<=ir_in. The event does not touch the FIFO.
- Pop: `cmd_valid & cmd_ready`; the head advances at the clock edge.
- Push and pop in the same cycle with the FIFO empty: no pop occurs (cmd_valid=0), and the push lands.
- `overflow`: sticky.
  - Set has priority over `clear_overflow` in the same cycle.
- take_action and take_no_action are combinational from the head entry. At most one bit across both vectors is high.
- Pointers are ADDR_W=$clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from `fifo_level` (0..DEPTH).

## Timing
- Reset values: cmd_valid=0, cmd_data=0, cmd_ir=0, take_action=0, take_no_action=0, ir_update=0, ir_value=0, fifo_level=0, overflow=0. Reset also clears the synchroniser chains, prev and armed.
- UDR latency: an input rise before clk edge 1 gives edge=1 after edge SYNC_STAGES. The push occurs at edge SYNC_STAGES+1, so cmd_valid=1 after edge 3 with the defaults.
- UIR latency is the same: ir_update is high in the cycle after edge SYNC_STAGES+1.
- The system guarantees TCK period ≥ (SYNC_STAGES+2) clk periods. Each strobe level therefore lasts ≥ SYNC_STAGES+1 cycles and yields exactly one event.
- Pop-to-next-head: 0 cycles. The new head is visible immediately after the popping edge.
- Reset mid-operation flushes the FIFO and discards in-flight sync events.

## Structure
- Shared package `debug_slave_pkg`: ACTION_BIT default, IR code constants (IR_OCIMEM=0, IR_TRACE=1, IR_BREAK=2, IR_TRACECTRL=3), a command-entry struct {ir, data}, and the clog2 helper.
- Sub-module `debug_slave_edge_sync`: parametrised SYNC_STAGES chain with arm logic and one-cycle rise pulse. It is instantiated twice (UDR, UIR).
- FIFO storage is an inline register array; no RAM inference is required at these depths.

## Test plan
- After reset, raise vs_udr with sr=38'h20_0000_0005 and ir_in=2. Required: cmd_valid=1 after edge 3, cmd_data=38'h20_0000_0005, take_action=4'b0100.
- Issue 5 UDR commands with DEPTH=4 and cmd_ready=0. Required: fifo_level=4, overflow=1, and the first 4 entries pop in order. Then clear_overflow → overflow=0.
- With a full FIFO and cmd_ready=1 on the push cycle: required level stays at 4, overflow stays 0, and the data ordering is preserved.
- Hold vs_udr high, pulse reset, release. Required: no push ever occurs, and cmd_valid=0 until vs_udr falls and rises again.
- Raise vs_uir with ir_in=3. Required: one-cycle ir_update after edge 3, ir_value=3, fifo_level unchanged.
- Push an entry with ACTION_BIT=0 and ir=1. Required: take_no_action=4'b0010 and take_action=0. Assert reset while the entry is queued → all outputs return to 0 on the next edge.

Source files
------------

// File: rtl/debug_slave_pkg.sv
// rtl/debug_slave_pkg.sv - shared constants, command entry type and clog2 helper for the debug slave
package debug_slave_pkg;

  localparam int DEFAULT_DATA_W     = 38;
  localparam int DEFAULT_IR_W       = 2;
  localparam int ACTION_BIT_DEFAULT = 37;

  localparam logic [DEFAULT_IR_W-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [DEFAULT_IR_W-1:0] IR_TRACE     = 2'd1;
  localparam logic [DEFAULT_IR_W-1:0] IR_BREAK     = 2'd2;
  localparam logic [DEFAULT_IR_W-1:0] IR_TRACECTRL = 2'd3;

  typedef struct packed {
    logic [DEFAULT_IR_W-1:0]   ir;
    logic [DEFAULT_DATA_W-1:0] data;
  } cmd_entry_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/debug_slave_edge_sync.sv
// rtl/debug_slave_edge_sync.sv - synchronises an async strobe level and emits a one-cycle rise pulse
module debug_slave_edge_sync
  import debug_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   armed_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // fill_q marks when sync_out carries a real sample rather than reset zeros,
  // so a strobe held high across reset release never arms the detector.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= sync_out;
      if (fill_q[SYNC_STAGES-1] && !sync_out) armed_q <= 1'b1;
    end
  end

  assign rise = sync_out & ~prev_q & armed_q;

endmodule

// File: rtl/debug_slave_cmd_queue.sv
// rtl/debug_slave_cmd_queue.sv - brings JTAG UDR/UIR strobes into clk and queues captured commands
module debug_slave_cmd_queue
  import debug_slave_pkg::*;
#(
  parameter  int DATA_W      = DEFAULT_DATA_W,
  parameter  int IR_W        = DEFAULT_IR_W,
  parameter  int DEPTH       = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int ACTION_BIT  = ACTION_BIT_DEFAULT,
  localparam int NUM_IR      = 2 ** IR_W,
  localparam int ADDR_W      = clog2(DEPTH),
  localparam int LEVEL_W     = ADDR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vs_udr,
  input  logic               vs_uir,
  input  logic [IR_W-1:0]    ir_in,
  input  logic [DATA_W-1:0]  sr,
  input  logic               cmd_ready,
  input  logic               clear_overflow,
  output logic               cmd_valid,
  output logic [DATA_W-1:0]  cmd_data,
  output logic [IR_W-1:0]    cmd_ir,
  output logic [NUM_IR-1:0]  take_action,
  output logic [NUM_IR-1:0]  take_no_action,
  output logic               ir_update,
  output logic [IR_W-1:0]    ir_value,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic               overflow
);

  localparam int ENTRY_W = IR_W + DATA_W;

  logic               udr_rise;
  logic               uir_rise;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               pop;
  logic               push;
  logic               drop;
  logic               action;

  debug_slave_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk    (clk),
    .reset  (reset),
    .strobe (vs_udr),
    .rise   (udr_rise)
  );

  debug_slave_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk    (clk),
    .reset  (reset),
    .strobe (vs_uir),
    .rise   (uir_rise)
  );

  // A full queue still accepts a capture when the consumer frees a slot in the same cycle.
  assign fifo_full = (fifo_level == LEVEL_W'(DEPTH));
  assign cmd_valid = (fifo_level != '0);
  assign pop       = cmd_valid & cmd_ready;
  assign push      = udr_rise & (~fifo_full | pop);
  assign drop      = udr_rise & fifo_full & ~pop;

  assign head     = cmd_valid ? mem[rd_ptr] : '0;
  assign cmd_ir   = head[ENTRY_W-1:DATA_W];
  assign cmd_data = head[DATA_W-1:0];
  assign action   = cmd_data[ACTION_BIT];

  assign take_action    = (cmd_valid &  action) ? (NUM_IR'(1) << cmd_ir) : '0;
  assign take_no_action = (cmd_valid & ~action) ? (NUM_IR'(1) << cmd_ir) : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ir_in, sr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      ir_update  <= 1'b0;
      ir_value   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LEVEL_W'(1);
        2'b01:   fifo_level <= fifo_level - LEVEL_W'(1);
        default: ;
      endcase
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
      ir_update <= uir_rise;
      if (uir_rise) ir_value <= ir_in;
    end
  end

endmodule
